// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranger scan controller: FSM state
// encoding, default timing constants and the channel-index width helper.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GUARD     = 3'd4
  } scan_state_e;

  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DEF_GUARD_US   = 10000;

  // A single-sensor build still needs a 1-bit channel field.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/ultrasonic_scan_ctrl_if.sv
// Result stream from the scan controller to the obstacle-avoidance logic:
// a one-cycle valid pulse with channel, echo width and timeout flag.
interface ultrasonic_scan_ctrl_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16
);
  import ultrasonic_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic             result_valid;
  logic [CH_W-1:0]  result_ch;
  logic [CNT_W-1:0] result_us;
  logic             result_timeout;

  modport master (
    output result_valid,
    output result_ch,
    output result_us,
    output result_timeout
  );

  modport slave (
    input result_valid,
    input result_ch,
    input result_us,
    input result_timeout
  );

endinterface

// File: rtl/echo_edge_det.sv
// Single-bit echo sampler with rise/fall pulse outputs.
// ECHO_SYNC_EN defined: 2-FF synchronizer; undefined: single sampling register.
module echo_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync_q;
  logic prev_q;

`ifdef ECHO_SYNC_EN
  logic meta_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= echo_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin sequencer for N_CH HC-SR04 style rangers: trigger, echo width
// measurement in us ticks, timeout reporting and guard gap. Honours ECHO_SYNC_EN.
module ultrasonic_scan_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 16,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int GUARD_US   = DEF_GUARD_US,
  localparam int CH_W      = ch_width(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_us_i,
  input  logic                  enable_i,
  input  logic [N_CH-1:0]       echo_i,
  output logic [N_CH-1:0]       trig_o,
  output logic                  busy_o,
  output logic [CH_W-1:0]       cur_ch_o,
  ultrasonic_scan_ctrl_if.master res
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TRIG_LIM  = CNT_W'(TRIG_US);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_US);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [N_CH-1:0]  trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic [CH_W-1:0]  rch_q, rch_d;
  logic [CNT_W-1:0] rus_q, rus_d;
  logic             rto_q, rto_d;

  logic [N_CH-1:0]  rise_s;
  logic [N_CH-1:0]  fall_s;
  logic             rise_cur_s;
  logic             fall_cur_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_echo
    echo_edge_det u_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .echo_i (echo_i[g]),
      .rise_o (rise_s[g]),
      .fall_o (fall_s[g])
    );
  end

  // Only the selected channel's edges matter; others are ignored.
  assign rise_cur_s = rise_s[ch_q];
  assign fall_cur_s = fall_s[ch_q];

  // Next-state, result capture, counter and registered output decode.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rv_d    = 1'b0;
    rch_d   = rch_q;
    rus_d   = rus_q;
    rto_d   = rto_q;

    case (state_q)
      IDLE: begin
        if (enable_i) state_d = TRIG;
        else          state_d = IDLE;
      end
      TRIG: begin
        if (cnt_q >= TRIG_LIM) state_d = WAIT_RISE;
        else                   state_d = TRIG;
      end
      WAIT_RISE: begin
        if (rise_cur_s) begin
          state_d = MEASURE;
        end else if (cnt_q >= TO_LIM) begin
          rv_d    = 1'b1;
          rch_d   = ch_q;
          rus_d   = TO_LIM;
          rto_d   = 1'b1;
          state_d = GUARD;
        end else begin
          state_d = WAIT_RISE;
        end
      end
      MEASURE: begin
        // Falling edge takes priority over a timeout on the same cycle.
        if (fall_cur_s) begin
          rv_d    = 1'b1;
          rch_d   = ch_q;
          rus_d   = cnt_q;
          rto_d   = 1'b0;
          state_d = GUARD;
        end else if (cnt_q >= TO_LIM) begin
          rv_d    = 1'b1;
          rch_d   = ch_q;
          rus_d   = TO_LIM;
          rto_d   = 1'b1;
          state_d = GUARD;
        end else begin
          state_d = MEASURE;
        end
      end
      GUARD: begin
        if (cnt_q >= GUARD_LIM) begin
          ch_d    = (ch_q == LAST_CH) ? {CH_W{1'b0}} : ch_q + CH_W'(1);
          state_d = enable_i ? TRIG : IDLE;
        end else begin
          state_d = GUARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick_us_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    trig_d = {N_CH{1'b0}};
    if (state_d == TRIG) begin
      trig_d[ch_d] = 1'b1;
    end else begin
      trig_d = {N_CH{1'b0}};
    end

    busy_d = (state_d != IDLE);
  end

  // State, counter, channel pointer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ch_q    <= {CH_W{1'b0}};
      trig_q  <= {N_CH{1'b0}};
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rch_q   <= {CH_W{1'b0}};
      rus_q   <= {CNT_W{1'b0}};
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rch_q   <= rch_d;
      rus_q   <= rus_d;
      rto_q   <= rto_d;
    end
  end

  assign trig_o             = trig_q;
  assign busy_o             = busy_q;
  assign cur_ch_o           = ch_q;
  assign res.result_valid   = rv_q;
  assign res.result_ch      = rch_q;
  assign res.result_us      = rus_q;
  assign res.result_timeout = rto_q;

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Scenario bench for ultrasonic_scan_ctrl with a result scoreboard; the
// coincident-edge scenario adapts its echo timing when ECHO_SYNC_EN is defined.
`timescale 1ns/1ps
module tb_ultrasonic_scan_ctrl;
  import ultrasonic_pkg::*;

  localparam int N_CH       = 3;
  localparam int CNT_W      = 16;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 200;
  localparam int GUARD_US   = 50;
  localparam int TICK_DIV   = 40;
  localparam int CH_W       = ch_width(N_CH);
  localparam int WAIT_MAX   = 400 * TICK_DIV;

  typedef struct {
    int ch;
    int us;
    bit to;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick_us = 1'b0;
  logic            enable;
  logic [N_CH-1:0] echo;
  logic [N_CH-1:0] trig;
  logic            busy;
  logic [CH_W-1:0] cur_ch;
  int              tick_cnt = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   max_ones = 0;

  ultrasonic_scan_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W)) res_if ();

  ultrasonic_scan_ctrl #(
    .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_US(TRIG_US),
    .TIMEOUT_US(TIMEOUT_US), .GUARD_US(GUARD_US)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tick_us_i(tick_us), .enable_i(enable),
    .echo_i(echo), .trig_o(trig), .busy_o(busy), .cur_ch_o(cur_ch),
    .res(res_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick_cnt == TICK_DIV - 1) begin
      tick_cnt <= 0;
      tick_us  <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      tick_us  <= 1'b0;
    end
  end

  // Scoreboard monitor plus trigger one-hot tracker.
  always @(negedge clk) begin
    if ($countones(trig) > max_ones) max_ones = $countones(trig);
    if (res_if.result_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got ch=%0d us=%0d to=%0d, wanted none",
                 res_if.result_ch, res_if.result_us, res_if.result_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(res_if.result_ch) !== mon_e.ch) begin
          bad++;
          $display("FAIL result_ch: got %0d wanted %0d", res_if.result_ch, mon_e.ch);
        end
        total++;
        if (res_if.result_timeout !== mon_e.to) begin
          bad++;
          $display("FAIL result_timeout ch%0d: got %0d wanted %0d",
                   mon_e.ch, res_if.result_timeout, mon_e.to);
        end
        total++;
        if ((int'(res_if.result_us) < mon_e.us - (mon_e.to ? 0 : 1)) ||
            (int'(res_if.result_us) > mon_e.us + (mon_e.to ? 0 : 1))) begin
          bad++;
          $display("FAIL result_us ch%0d: got %0d wanted %0d", mon_e.ch, res_if.result_us, mon_e.us);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (tick_us) k++;
    end
  endtask

  task automatic wait_trig_rise(output int ch);
    int cyc = 0;
    ch = -1;
    while (trig == {N_CH{1'b0}} && cyc < WAIT_MAX) begin
      @(negedge clk);
      cyc++;
    end
    if (trig == {N_CH{1'b0}}) begin
      total++;
      bad++;
      $display("FAIL trig_rise_wait: got no trigger, wanted one within %0d cycles", WAIT_MAX);
    end else begin
      for (int i = 0; i < N_CH; i++) if (trig[i]) ch = i;
    end
  endtask

  task automatic wait_trig_fall();
    int cyc = 0;
    while (trig != {N_CH{1'b0}} && cyc < WAIT_MAX) begin
      @(negedge clk);
      cyc++;
    end
    if (trig != {N_CH{1'b0}}) begin
      total++;
      bad++;
      $display("FAIL trig_fall_wait: got trig=%b, wanted 0", trig);
    end
  endtask

  task automatic wait_result();
    int cyc = 0;
    while (res_if.result_valid !== 1'b1 && cyc < WAIT_MAX) begin
      @(negedge clk);
      cyc++;
    end
    if (res_if.result_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL result_wait: got no result_valid, wanted one within %0d cycles", WAIT_MAX);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    echo = {N_CH{1'b0}};
    repeat (3) @(negedge clk);
    total++; if (trig !== {N_CH{1'b0}}) begin bad++; $display("FAIL reset_trig: got %b wanted 000", trig); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b wanted 0", busy); end
    total++; if (cur_ch !== {CH_W{1'b0}}) begin bad++; $display("FAIL reset_cur_ch: got %0d wanted 0", cur_ch); end
    total++; if (res_if.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b wanted 0", res_if.result_valid); end
    total++; if (res_if.result_us !== {CNT_W{1'b0}}) begin bad++; $display("FAIL reset_us: got %0d wanted 0", res_if.result_us); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal_read();
    int ch;
    int n = 0;
    int cyc = 0;
    exp_q.push_back('{0, 58, 1'b0});
    enable = 1'b1;
    wait_trig_rise(ch);
    total++; if (ch !== 0) begin bad++; $display("FAIL normal_trig_ch: got %0d wanted 0", ch); end
    while (trig[0] === 1'b1 && cyc < WAIT_MAX) begin
      if (tick_us) n++;
      @(negedge clk);
      cyc++;
    end
    total++; if (n !== TRIG_US) begin bad++; $display("FAIL trig_width: got %0d ticks wanted %0d", n, TRIG_US); end
    wait_ticks(20);
    echo[0] = 1'b1;
    wait_ticks(58);
    echo[0] = 1'b0;
    wait_result();
  endtask

  task automatic test_no_echo();
    int ch;
    int n = 0;
    int cyc = 0;
    exp_q.push_back('{1, TIMEOUT_US, 1'b1});
    wait_trig_rise(ch);
    total++; if (ch !== 1) begin bad++; $display("FAIL noecho_trig_ch: got %0d wanted 1", ch); end
    wait_result();
    // Ch2 echo goes stuck-high before its trigger for the next scenario.
    exp_q.push_back('{2, TIMEOUT_US, 1'b1});
    echo[2] = 1'b1;
    while (trig == {N_CH{1'b0}} && cyc < WAIT_MAX) begin
      if (tick_us) n++;
      @(negedge clk);
      cyc++;
    end
    total++; if (trig !== 3'b100) begin bad++; $display("FAIL guard_next_trig: got %b wanted 100", trig); end
    total++; if (n < GUARD_US - 1 || n > GUARD_US + 1) begin bad++; $display("FAIL guard_gap: got %0d ticks wanted %0d", n, GUARD_US); end
  endtask

  task automatic test_stuck_high();
    int ch;
    wait_result();
    echo[2] = 1'b0;
    wait_trig_rise(ch);
    total++; if (trig !== 3'b001) begin bad++; $display("FAIL wrap_trig: got %b wanted 001", trig); end
    total++; if (max_ones > 1) begin bad++; $display("FAIL trig_onehot: got %0d bits high wanted <=1", max_ones); end
  endtask

  task automatic test_enable_drop();
    exp_q.push_back('{0, 30, 1'b0});
    wait_trig_fall();
    wait_ticks(5);
    echo[0] = 1'b1;
    wait_ticks(10);
    enable = 1'b0;
    wait_ticks(20);
    echo[0] = 1'b0;
    wait_result();
    wait_ticks(GUARD_US + 10);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b wanted 0", busy); end
    total++; if (cur_ch !== CH_W'(1)) begin bad++; $display("FAIL idle_cur_ch: got %0d wanted 1", cur_ch); end
    total++; if (trig !== {N_CH{1'b0}}) begin bad++; $display("FAIL idle_trig: got %b wanted 000", trig); end
    total++; if (res_if.result_ch !== CH_W'(0)) begin bad++; $display("FAIL result_hold_ch: got %0d wanted 0", res_if.result_ch); end
  endtask

  task automatic test_reset_mid();
    int ch;
    enable = 1'b1;
    wait_trig_rise(ch);
    total++; if (ch !== 1) begin bad++; $display("FAIL resume_trig_ch: got %0d wanted 1", ch); end
    wait_ticks(3);
    rst = 1'b1;
    @(negedge clk);
    total++; if (trig !== {N_CH{1'b0}}) begin bad++; $display("FAIL rst_mid_trig: got %b wanted 000", trig); end
    total++; if (res_if.result_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b wanted 0", res_if.result_valid); end
    total++; if (cur_ch !== {CH_W{1'b0}}) begin bad++; $display("FAIL rst_mid_cur_ch: got %0d wanted 0", cur_ch); end
    rst = 1'b0;
    wait_trig_rise(ch);
    total++; if (ch !== 0) begin bad++; $display("FAIL restart_trig_ch: got %0d wanted 0", ch); end
  endtask

  task automatic test_coincident();
    exp_q.push_back('{0, TIMEOUT_US, 1'b0});
    wait_trig_fall();
    wait_ticks(5);
    @(negedge clk);
    echo[0] = 1'b1;
    // Align the synced falling edge with the cycle the count hits the limit.
`ifdef ECHO_SYNC_EN
    wait_ticks(TIMEOUT_US - 1);
    while (tick_cnt != TICK_DIV - 1) @(negedge clk);
`else
    wait_ticks(TIMEOUT_US);
`endif
    echo[0] = 1'b0;
    wait_result();
    total++; if (res_if.result_timeout !== 1'b0) begin bad++; $display("FAIL coincident_timeout: got %b wanted 0", res_if.result_timeout); end
    total++; if (res_if.result_us !== CNT_W'(TIMEOUT_US)) begin bad++; $display("FAIL coincident_us: got %0d wanted %0d", res_if.result_us, TIMEOUT_US); end
    enable = 1'b0;
    wait_ticks(2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending wanted 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_normal_read();
    test_no_echo();
    test_stuck_high();
    test_enable_drop();
    test_reset_mid();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
